mdu_issue: RTL and testbench

E-stage issue controller placed directly upstream of the multiply/divide unit (MDU). It accepts MDU-class instructions from the ID/EX register and launches them into the MDU with a registered start pulse and operands. It stalls the E stage while the MDU is occupied and returns HI/LO reads (mfhi/mflo) to the M stage as registered data. It is the only driver of the MDU's start, control and operand inputs.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_issue_if.sv | 26 ++
 rtl/mdu_issue.sv | 114 +++++++++++
 tb/tb_mdu_issue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op codes, class decode and issue FSM states
//
// Op encoding is common to mdu_issue and the MDU itself.
package mdu_pkg;

    localparam logic [3:0] OP_MULT   = 4'd0;
    localparam logic [3:0] OP_MULTU  = 4'd1;
    localparam logic [3:0] OP_DIV    = 4'd2;
    localparam logic [3:0] OP_DIVU   = 4'd3;
    localparam logic [3:0] OP_MFHI   = 4'd4;
    localparam logic [3:0] OP_MFLO   = 4'd5;
    localparam logic [3:0] OP_MTHI   = 4'd6;
    localparam logic [3:0] OP_MTLO   = 4'd7;
    localparam logic [3:0] OP_MAROTR = 4'd8;
    localparam logic [3:0] OP_NONE   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Ops that start a multi-cycle MDU computation.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
               (op == OP_DIVU) || (op == OP_MAROTR);
    endfunction

    // Single-cycle HI/LO writes.
    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

    // HI/LO reads served directly from the MDU outputs.
    function automatic logic is_mf(input logic [3:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/mdu_issue_if.sv
// rtl/mdu_issue_if.sv - issue-controller to MDU connection
//
// master: issue side (drives start/ctrl/operands, observes busy/HI/LO)
// slave : MDU side
interface mdu_issue_if;

    logic        mdu_start;
    logic [3:0]  mdu_ctrl;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [4:0]  mdu_sa;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    modport master (
        output mdu_start, mdu_ctrl, mdu_a, mdu_b, mdu_sa,
        input  mdu_busy, mdu_hi, mdu_lo
    );

    modport slave (
        input  mdu_start, mdu_ctrl, mdu_a, mdu_b, mdu_sa,
        output mdu_busy, mdu_hi, mdu_lo
    );

endinterface

// File: rtl/mdu_issue.sv
// rtl/mdu_issue.sv - E-stage issue controller in front of the multiply/divide unit
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   op_valid_e, op_e    E-stage instruction valid and MDU op code
//   rs_val_e, rt_val_e  forwarded operands
//   sa_e                shift amount (MAROTR)
//   flush_e             kill the E-stage instruction this cycle
//   mdu                 MDU connection (master side)
//   stall_e             hold E stage and upstream (combinational)
//   mf_valid_m          mf_data_m valid this cycle
//   mf_data_m           mfhi/mflo result for the M stage
module mdu_issue
    import mdu_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         op_valid_e,
    input  logic [3:0]   op_e,
    input  logic [31:0]  rs_val_e,
    input  logic [31:0]  rt_val_e,
    input  logic [4:0]   sa_e,
    input  logic         flush_e,
    mdu_issue_if.master  mdu,
    output logic         stall_e,
    output logic         mf_valid_m,
    output logic [31:0]  mf_data_m
);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_start;
    logic [3:0]  r_ctrl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_sa;
    logic        r_mf_valid;
    logic [31:0] r_mf_data;

    logic w_is_arith;
    logic w_is_mt;
    logic w_is_mf;
    logic w_req;
    logic w_accept;

    assign w_is_arith = is_arith(op_e);
    assign w_is_mt    = is_mt(op_e);
    assign w_is_mf    = is_mf(op_e);
    assign w_req      = op_valid_e & (w_is_arith | w_is_mt | w_is_mf) & ~flush_e;
    assign w_accept   = w_req & (r_state == ST_IDLE) & ~mdu.mdu_busy;

    always_comb begin
        w_state_next = r_state;
        stall_e      = w_req & ((r_state != ST_IDLE) | mdu.mdu_busy);
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_is_arith || w_is_mt)) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // r_ctrl still holds the launched op here; mt ops finish at this edge.
                w_state_next = is_arith(r_ctrl) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (!mdu.mdu_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_ctrl     <= OP_NONE;
            r_a        <= '0;
            r_b        <= '0;
            r_sa       <= '0;
            r_mf_valid <= 1'b0;
            r_mf_data  <= '0;
        end else begin
            r_state    <= w_state_next;
            // Start and ctrl are live only during LAUNCH; an mt code left on
            // mdu_ctrl would rewrite HI/LO every cycle.
            r_start    <= 1'b0;
            r_ctrl     <= OP_NONE;
            r_mf_valid <= 1'b0;
            if (w_accept) begin
                if (w_is_arith || w_is_mt) begin
                    r_start <= w_is_arith;
                    r_ctrl  <= op_e;
                    r_a     <= rs_val_e;
                    r_b     <= rt_val_e;
                    r_sa    <= sa_e;
                end else begin
                    r_mf_valid <= 1'b1;
                    r_mf_data  <= (op_e == OP_MFHI) ? mdu.mdu_hi : mdu.mdu_lo;
                end
            end
        end
    end

    assign mdu.mdu_start = r_start;
    assign mdu.mdu_ctrl  = r_ctrl;
    assign mdu.mdu_a     = r_a;
    assign mdu.mdu_b     = r_b;
    assign mdu.mdu_sa    = r_sa;
    assign mf_valid_m    = r_mf_valid;
    assign mf_data_m     = r_mf_data;

endmodule

// File: tb/tb_mdu_issue.sv
// tb/tb_mdu_issue.sv - directed self-checking bench for mdu_issue with a behavioural MDU
module tb_mdu_issue;
    import mdu_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        op_valid_e;
    logic [3:0]  op_e;
    logic [31:0] rs_val_e;
    logic [31:0] rt_val_e;
    logic [4:0]  sa_e;
    logic        flush_e;
    logic        stall_e;
    logic        mf_valid_m;
    logic [31:0] mf_data_m;

    int errors;
    int checks;

    mdu_issue_if mif ();

    mdu_issue dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .op_valid_e (op_valid_e),
        .op_e       (op_e),
        .rs_val_e   (rs_val_e),
        .rt_val_e   (rt_val_e),
        .sa_e       (sa_e),
        .flush_e    (flush_e),
        .mdu        (mif.master),
        .stall_e    (stall_e),
        .mf_valid_m (mf_valid_m),
        .mf_data_m  (mf_data_m)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural MDU: busy from the edge after start; mult-class writes
    // HI/LO 4 edges later, div-class 9 edges later; mt writes at the LAUNCH edge.
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_sa;
    int          m_cnt;

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sa);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic [63:0] r;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        r = '0;
        case (op)
            OP_MULT:   r = sa64 * sb64;
            OP_MULTU:  r = {32'd0, a} * {32'd0, b};
            OP_DIV:    if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            OP_DIVU:   if (b != 0) r = {a % b, a / b};
            OP_MAROTR: r = {32'd0, (a >> sa) | (a << (6'd32 - {1'b0, sa}))};
            default:   r = '0;
        endcase
        return r;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            mif.mdu_busy <= 1'b0;
            mif.mdu_hi   <= '0;
            mif.mdu_lo   <= '0;
            m_cnt        <= 0;
        end else if (mif.mdu_start) begin
            mif.mdu_busy <= 1'b1;
            m_op  <= mif.mdu_ctrl;
            m_a   <= mif.mdu_a;
            m_b   <= mif.mdu_b;
            m_sa  <= mif.mdu_sa;
            m_cnt <= (mif.mdu_ctrl == OP_DIV || mif.mdu_ctrl == OP_DIVU) ? 9 : 4;
        end else if (mif.mdu_busy) begin
            if (m_cnt == 1) begin
                mif.mdu_busy <= 1'b0;
                {mif.mdu_hi, mif.mdu_lo} <= mdu_calc(m_op, m_a, m_b, m_sa);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mif.mdu_ctrl == OP_MTHI) begin
            mif.mdu_hi <= mif.mdu_a;
        end else if (mif.mdu_ctrl == OP_MTLO) begin
            mif.mdu_lo <= mif.mdu_a;
        end
    end

    task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic fl);
        op_valid_e = v;
        op_e       = op;
        rs_val_e   = rs;
        rt_val_e   = rt;
        sa_e       = 5'd0;
        flush_e    = fl;
    endtask

    // Counts consecutive stalled cycles (sampled at negedge), bounded.
    task automatic count_stalls(output int n);
        n = 0;
        @(negedge Clk);
        while (stall_e && n < 40) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        set_in(1'b1, OP_MULT, 32'd3, 32'd4, 1'b0);
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (mif.mdu_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", mif.mdu_start); end
        checks++; if (mif.mdu_ctrl !== OP_NONE) begin errors++; $display("FAIL reset_ctrl got=%h exp=f", mif.mdu_ctrl); end
        checks++; if (mif.mdu_a !== 32'd0 || mif.mdu_b !== 32'd0) begin errors++; $display("FAIL reset_ab got=%h/%h exp=0/0", mif.mdu_a, mif.mdu_b); end
        checks++; if (mif.mdu_sa !== 5'd0) begin errors++; $display("FAIL reset_sa got=%h exp=0", mif.mdu_sa); end
        checks++; if (mf_valid_m !== 1'b0 || mf_data_m !== 32'd0) begin errors++; $display("FAIL reset_mf got=%b/%h exp=0/0", mf_valid_m, mf_data_m); end
        @(negedge Clk);
        checks++; if (stall_e !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_e); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_mult;
        int n;
        @(negedge Clk);
        set_in(1'b1, OP_MULT, 32'd3, 32'hFFFFFFFB, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mif.mdu_start !== 1'b1 || mif.mdu_ctrl !== OP_MULT) begin errors++; $display("FAIL mult_launch got start=%b ctrl=%h exp 1/0", mif.mdu_start, mif.mdu_ctrl); end
        checks++; if (mif.mdu_a !== 32'd3 || mif.mdu_b !== 32'hFFFFFFFB) begin errors++; $display("FAIL mult_ops got=%h/%h exp=3/fffffffb", mif.mdu_a, mif.mdu_b); end
        set_in(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        count_stalls(n);
        checks++; if (n !== 6) begin errors++; $display("FAIL mult_stall_cycles got=%0d exp=6", n); end
        checks++; if (mif.mdu_ctrl !== OP_NONE || mif.mdu_start !== 1'b0) begin errors++; $display("FAIL mult_ctrl_idle got=%h/%b exp=f/0", mif.mdu_ctrl, mif.mdu_start); end
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_mflo got=%b/%h exp=1/fffffff1", mf_valid_m, mf_data_m); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b0) begin errors++; $display("FAIL mf_pulse got=%b exp=0", mf_valid_m); end
    endtask

    task automatic test_divu;
        int n;
        @(negedge Clk);
        set_in(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        @(posedge Clk); #1;
        set_in(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        count_stalls(n);
        checks++; if (n !== 11) begin errors++; $display("FAIL divu_stall_cycles got=%0d exp=11", n); end
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'd2) begin errors++; $display("FAIL divu_mfhi got=%b/%h exp=1/2", mf_valid_m, mf_data_m); end
        set_in(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mf_data_m !== 32'd14) begin errors++; $display("FAIL divu_mflo got=%h exp=e", mf_data_m); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_mthi;
        int n;
        @(negedge Clk);
        set_in(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mif.mdu_start !== 1'b0 || mif.mdu_ctrl !== OP_MTHI) begin errors++; $display("FAIL mt_launch got start=%b ctrl=%h exp 0/6", mif.mdu_start, mif.mdu_ctrl); end
        set_in(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        count_stalls(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL mt_stall_cycles got=%0d exp=1", n); end
        checks++; if (mif.mdu_start !== 1'b0 || mif.mdu_ctrl !== OP_NONE) begin errors++; $display("FAIL mt_after got start=%b ctrl=%h exp 0/f", mif.mdu_start, mif.mdu_ctrl); end
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'hDEADBEEF) begin errors++; $display("FAIL mt_mfhi got=%b/%h exp=1/deadbeef", mf_valid_m, mf_data_m); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
    endtask

    task automatic test_flush;
        int n;
        // Flush in the request cycle: nothing launches, HI keeps DEADBEEF.
        @(negedge Clk);
        set_in(1'b1, OP_DIV, 32'd9, 32'd2, 1'b1);
        #1;
        checks++; if (stall_e !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_e); end
        @(posedge Clk); #1;
        checks++; if (mif.mdu_start !== 1'b0 || mif.mdu_ctrl !== OP_NONE || mf_valid_m !== 1'b0) begin errors++; $display("FAIL flush_nolaunch got start=%b ctrl=%h mfv=%b exp 0/f/0", mif.mdu_start, mif.mdu_ctrl, mf_valid_m); end
        set_in(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'hDEADBEEF) begin errors++; $display("FAIL flush_hi_kept got=%b/%h exp=1/deadbeef", mf_valid_m, mf_data_m); end
        // Flush after acceptance: op completes.
        set_in(1'b1, OP_DIV, 32'hFFFFFFEC, 32'd3, 1'b0);
        @(posedge Clk); #1;
        checks++; if (mif.mdu_start !== 1'b1) begin errors++; $display("FAIL flush_late_launch got=%b exp=1", mif.mdu_start); end
        set_in(1'b1, OP_DIV, 32'd1, 32'd1, 1'b1);
        @(posedge Clk); #1;
        set_in(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        count_stalls(n);
        checks++; if (n !== 10) begin errors++; $display("FAIL flush_late_stall got=%0d exp=10", n); end
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'hFFFFFFFA) begin errors++; $display("FAIL flush_late_quot got=%b/%h exp=1/fffffffa", mf_valid_m, mf_data_m); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_op;
        @(negedge Clk);
        set_in(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0);
        @(posedge Clk); #1;
        set_in(1'b1, OP_MFLO, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (stall_e !== 1'b1) begin errors++; $display("FAIL rst_mid_wait_stall got=%b exp=1", stall_e); end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++; if (stall_e !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", stall_e); end
        @(posedge Clk); #1;
        checks++; if (mf_valid_m !== 1'b1 || mf_data_m !== 32'd0) begin errors++; $display("FAIL rst_mid_mflo got=%b/%h exp=1/0", mf_valid_m, mf_data_m); end
        set_in(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
        @(posedge Clk); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mult();
        test_divu();
        test_mthi();
        test_flush();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
